// File: rtl/doodle_motion_ctrl_if.sv
// Bundles the per-frame controls and the motion state outputs of the
// doodle motion controller so the game logic can be wired with one port.
interface doodle_motion_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       ack;
    logic       landed;
    logic [9:0] doodle_y;
    logic [9:0] up_count;
    logic [9:0] scroll;
    logic [7:0] score;
    logic       in_middle;
    logic       q_Idle;
    logic       q_Rise;
    logic       q_Fall;
    logic       q_Over;

    modport master (
        output frame_tick, start, ack, landed,
        input  doodle_y, up_count, scroll, score, in_middle,
        input  q_Idle, q_Rise, q_Fall, q_Over
    );

    modport slave (
        input  frame_tick, start, ack, landed,
        output doodle_y, up_count, scroll, score, in_middle,
        output q_Idle, q_Rise, q_Fall, q_Over
    );
endinterface

// File: rtl/doodle_motion_ctrl.sv
// Vertical motion controller for the doodle: rises a fixed distance per
// jump (scrolling the stage once the doodle reaches the middle band),
// falls until it lands on a platform or drops off the bottom, and keeps a
// saturating score of pixels risen during the current game.
module doodle_motion_ctrl #(
    parameter logic [9:0] JUMP_HEIGHT = 10'd120,
    parameter logic [9:0] Y_START     = 10'd480,
    parameter logic [9:0] V_MIDDLE    = 10'd275,
    parameter logic [9:0] V_BOTTOM    = 10'd515,
    parameter logic [9:0] RADIUS      = 10'd10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    doodle_motion_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        RISE = 4'b0010,
        FALL = 4'b0100,
        OVER = 4'b1000
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [9:0] doodle_y;
    logic [9:0] doodle_y_next;
    logic [9:0] up_count;
    logic [9:0] up_count_next;
    logic [9:0] scroll;
    logic [9:0] scroll_next;
    logic [7:0] score;
    logic [7:0] score_next;
    logic       in_middle;
    logic       in_middle_next;
    logic       bottom_reached;
    logic       jump_done;

    // Widened by one bit so the bottom test can never wrap for large rows.
    assign bottom_reached = ({1'b0, doodle_y} + {1'b0, RADIUS}) >= {1'b0, V_BOTTOM};
    assign jump_done      = (up_count >= JUMP_HEIGHT);

    // in_middle tracks the row being loaded, so it changes on the same edge.
    assign in_middle_next = (doodle_y_next <= V_MIDDLE);

    // Next-state and next-datapath decisions; everything holds unless a
    // state's sampling condition says otherwise.
    always_comb begin
        state_next    = state;
        doodle_y_next = doodle_y;
        up_count_next = up_count;
        scroll_next   = scroll;
        score_next    = score;

        case (state)
            IDLE: begin
                doodle_y_next = Y_START;
                up_count_next = '0;
                scroll_next   = '0;
                if (bus.start) begin
                    state_next = RISE;
                    score_next = '0;
                end
            end

            RISE: begin
                if (bus.frame_tick) begin
                    if (jump_done) begin
                        state_next    = FALL;
                        up_count_next = '0;
                    end else begin
                        up_count_next = up_count + 10'd1;
                        if (score != 8'hFF) begin
                            score_next = score + 8'd1;
                        end
                        if (doodle_y > V_MIDDLE) begin
                            doodle_y_next = doodle_y - 10'd1;
                        end else begin
                            scroll_next = scroll + 10'd1;
                        end
                    end
                end
            end

            FALL: begin
                if (bus.frame_tick) begin
                    if (bus.landed) begin
                        state_next    = RISE;
                        up_count_next = '0;
                    end else if (bottom_reached) begin
                        state_next = OVER;
                    end else begin
                        doodle_y_next = doodle_y + 10'd1;
                    end
                end
            end

            OVER: begin
                if (bus.ack) begin
                    state_next    = IDLE;
                    doodle_y_next = Y_START;
                    up_count_next = '0;
                    scroll_next   = '0;
                end
            end

            default: begin
                state_next    = IDLE;
                doodle_y_next = Y_START;
                up_count_next = '0;
                scroll_next   = '0;
            end
        endcase
    end

    // State register; reset drops any jump in progress back to IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Motion and score registers, loaded from the next-value logic.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            doodle_y  <= Y_START;
            up_count  <= '0;
            scroll    <= '0;
            score     <= '0;
            in_middle <= (Y_START <= V_MIDDLE);
        end else begin
            doodle_y  <= doodle_y_next;
            up_count  <= up_count_next;
            scroll    <= scroll_next;
            score     <= score_next;
            in_middle <= in_middle_next;
        end
    end

    assign bus.doodle_y  = doodle_y;
    assign bus.up_count  = up_count;
    assign bus.scroll    = scroll;
    assign bus.score     = score;
    assign bus.in_middle = in_middle;
    assign bus.q_Idle    = state[0];
    assign bus.q_Rise    = state[1];
    assign bus.q_Fall    = state[2];
    assign bus.q_Over    = state[3];

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Testbench for doodle_motion_ctrl: three instances with different jump
// heights / start rows, a behavioural model feeding a scoreboard queue,
// plus fixed-value checks at the points the behaviour is easy to reason about.
module tb_doodle_motion_ctrl;

    typedef struct packed {
        logic [3:0] st;     // {over, fall, rise, idle}
        logic [9:0] y;
        logic [9:0] up;
        logic [9:0] scroll;
        logic [7:0] score;
        logic       mid;
    } mstate_t;

    typedef struct packed {
        logic [1:0] inst;
        mstate_t    exp;
    } sb_t;

    logic Clk;
    logic Reset;

    doodle_motion_ctrl_if bus0 ();
    doodle_motion_ctrl_if bus1 ();
    doodle_motion_ctrl_if bus2 ();

    doodle_motion_ctrl #(.JUMP_HEIGHT(10'd4)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    doodle_motion_ctrl #(.JUMP_HEIGHT(10'd8), .Y_START(10'd280)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    doodle_motion_ctrl #(.JUMP_HEIGHT(10'd300)) dut2 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus2.slave)
    );

    int      check_count = 0;
    int      error_count = 0;
    mstate_t model [3];
    int      jump_h [3] = '{4, 8, 300};
    int      y_start [3] = '{480, 280, 480};
    sb_t     sbq [$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout reached observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic mstate_t reset_state(input int ys);
        mstate_t r;
        r.st     = 4'b0001;
        r.y      = ys[9:0];
        r.up     = '0;
        r.scroll = '0;
        r.score  = '0;
        r.mid    = (ys <= 275);
        return r;
    endfunction

    // Behavioural model of one frame-controller step.
    function automatic mstate_t model_next(input mstate_t s, input int jh, input int ys,
                                           input bit tick, input bit st_in,
                                           input bit ack_in, input bit landed_in);
        mstate_t n = s;
        case (s.st)
            4'b0001: if (st_in) begin
                n.st    = 4'b0010;
                n.score = '0;
            end
            4'b0010: if (tick) begin
                if (s.up >= jh) begin
                    n.st = 4'b0100;
                    n.up = '0;
                end else begin
                    n.up = s.up + 10'd1;
                    n.score = (s.score == 8'd255) ? 8'd255 : s.score + 8'd1;
                    if (s.y > 275) n.y = s.y - 10'd1;
                    else           n.scroll = s.scroll + 10'd1;
                end
            end
            4'b0100: if (tick) begin
                if (landed_in) begin
                    n.st = 4'b0010;
                    n.up = '0;
                end else if (s.y + 10 >= 515) begin
                    n.st = 4'b1000;
                end else begin
                    n.y = s.y + 10'd1;
                end
            end
            4'b1000: if (ack_in) begin
                n.st     = 4'b0001;
                n.y      = ys[9:0];
                n.up     = '0;
                n.scroll = '0;
            end
            default: n = reset_state(ys);
        endcase
        n.mid = (n.y <= 275);
        return n;
    endfunction

    function automatic mstate_t observe(input int k);
        mstate_t o;
        case (k)
            0: o = '{{bus0.q_Over, bus0.q_Fall, bus0.q_Rise, bus0.q_Idle}, bus0.doodle_y,
                     bus0.up_count, bus0.scroll, bus0.score, bus0.in_middle};
            1: o = '{{bus1.q_Over, bus1.q_Fall, bus1.q_Rise, bus1.q_Idle}, bus1.doodle_y,
                     bus1.up_count, bus1.scroll, bus1.score, bus1.in_middle};
            default: o = '{{bus2.q_Over, bus2.q_Fall, bus2.q_Rise, bus2.q_Idle}, bus2.doodle_y,
                     bus2.up_count, bus2.scroll, bus2.score, bus2.in_middle};
        endcase
        return o;
    endfunction

    task automatic compare_state(input string pfx, input mstate_t o, input mstate_t e);
        checkOutput({pfx, "_state"},    32'(o.st),     32'(e.st));
        checkOutput({pfx, "_y"},        32'(o.y),      32'(e.y));
        checkOutput({pfx, "_up"},       32'(o.up),     32'(e.up));
        checkOutput({pfx, "_scroll"},   32'(o.scroll), 32'(e.scroll));
        checkOutput({pfx, "_score"},    32'(o.score),  32'(e.score));
        checkOutput({pfx, "_mid"},      32'(o.mid),    32'(e.mid));
    endtask

    // Drives one cycle of inputs on instance k, queues the expected result
    // and compares it one edge later.
    task automatic applyStimulus(input int k, input bit tick, input bit st_in,
                                 input bit ack_in, input bit landed_in);
        sb_t ent;
        bus0.frame_tick = 0; bus0.start = 0; bus0.ack = 0; bus0.landed = 0;
        bus1.frame_tick = 0; bus1.start = 0; bus1.ack = 0; bus1.landed = 0;
        bus2.frame_tick = 0; bus2.start = 0; bus2.ack = 0; bus2.landed = 0;
        case (k)
            0: begin bus0.frame_tick = tick; bus0.start = st_in; bus0.ack = ack_in; bus0.landed = landed_in; end
            1: begin bus1.frame_tick = tick; bus1.start = st_in; bus1.ack = ack_in; bus1.landed = landed_in; end
            default: begin bus2.frame_tick = tick; bus2.start = st_in; bus2.ack = ack_in; bus2.landed = landed_in; end
        endcase
        model[k] = model_next(model[k], jump_h[k], y_start[k], tick, st_in, ack_in, landed_in);
        ent.inst = 2'(k);
        ent.exp  = model[k];
        sbq.push_back(ent);
        @(posedge Clk);
        #1;
        if (sbq.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            ent = sbq.pop_front();
            compare_state("sb", observe(int'(ent.inst)), ent.exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus0.frame_tick = 0; bus0.start = 0; bus0.ack = 0; bus0.landed = 0;
        bus1.frame_tick = 0; bus1.start = 0; bus1.ack = 0; bus1.landed = 0;
        bus2.frame_tick = 0; bus2.start = 0; bus2.ack = 0; bus2.landed = 0;
        for (int k = 0; k < 3; k++) model[k] = reset_state(y_start[k]);
        #12;
        $display("[TB] reset state");
        for (int k = 0; k < 3; k++) compare_state("reset", observe(k), model[k]);
        checkOutput("reset_y0", 32'(bus0.doodle_y), 32'd480);
        checkOutput("reset_idle1", 32'(bus1.q_Idle), 32'd1);
        @(negedge Clk);
        Reset = 1'b0;

        // Instance 0: short jump, fall to the bottom, game over.
        $display("[TB] short jump and game over");
        applyStimulus(0, 1, 0, 0, 0);          // tick in IDLE ignored
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("start_rise", 32'(bus0.q_Rise), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 1);
        checkOutput("y_after_4", 32'(bus0.doodle_y), 32'd476);
        checkOutput("up_after_4", 32'(bus0.up_count), 32'd4);
        checkOutput("score_after_4", 32'(bus0.score), 32'd4);
        applyStimulus(0, 0, 0, 0, 0);          // no tick: hold
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("fall_state", 32'(bus0.q_Fall), 32'd1);
        checkOutput("fall_up", 32'(bus0.up_count), 32'd0);
        checkOutput("fall_y", 32'(bus0.doodle_y), 32'd476);
        for (int i = 0; i < 29; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("fall_y_505", 32'(bus0.doodle_y), 32'd505);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("over_state", 32'(bus0.q_Over), 32'd1);
        checkOutput("over_y", 32'(bus0.doodle_y), 32'd505);
        applyStimulus(0, 1, 1, 0, 1);          // start/landed ignored in OVER
        checkOutput("over_hold", 32'(bus0.q_Over), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ack_idle", 32'(bus0.q_Idle), 32'd1);
        checkOutput("ack_y", 32'(bus0.doodle_y), 32'd480);
        checkOutput("ack_score", 32'(bus0.score), 32'd4);

        // Instance 1: reach the middle band, then scroll.
        $display("[TB] middle band scrolling");
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("mid_y", 32'(bus1.doodle_y), 32'd275);
        checkOutput("mid_flag", 32'(bus1.in_middle), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("mid_scroll", 32'(bus1.scroll), 32'd3);
        checkOutput("mid_y_held", 32'(bus1.doodle_y), 32'd275);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("mid_fall", 32'(bus1.q_Fall), 32'd1);

        // Instance 0 again: landing beats the bottom test, ack ignored in RISE.
        $display("[TB] landing at the bottom row");
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("restart_score", 32'(bus0.score), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 29; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("land_rise", 32'(bus0.q_Rise), 32'd1);
        checkOutput("land_y", 32'(bus0.doodle_y), 32'd505);
        checkOutput("land_up", 32'(bus0.up_count), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ack_in_rise", 32'(bus0.q_Rise), 32'd1);
        applyStimulus(0, 1, 0, 0, 0);

        // Instance 2: long jumps, score saturation and scroll wrap.
        $display("[TB] saturation and wrap");
        applyStimulus(2, 0, 1, 0, 0);
        for (int i = 0; i < 300; i++) applyStimulus(2, 1, 0, 0, 0);
        checkOutput("long_up", 32'(bus2.up_count), 32'd300);
        checkOutput("long_score", 32'(bus2.score), 32'd255);
        checkOutput("long_scroll", 32'(bus2.scroll), 32'd95);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(2, 1, 0, 0, 0);
            applyStimulus(2, 1, 0, 0, 1);
            for (int i = 0; i < 300; i++) applyStimulus(2, 1, 0, 0, 0);
        end
        applyStimulus(2, 1, 0, 0, 0);
        applyStimulus(2, 1, 0, 0, 1);
        for (int i = 0; i < 28; i++) applyStimulus(2, 1, 0, 0, 0);
        checkOutput("scroll_1023", 32'(bus2.scroll), 32'd1023);
        applyStimulus(2, 1, 0, 0, 0);
        checkOutput("scroll_wrap", 32'(bus2.scroll), 32'd0);

        // Asynchronous reset in the middle of instance 0's jump.
        $display("[TB] asynchronous reset mid-jump");
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) model[k] = reset_state(y_start[k]);
        checkOutput("areset_idle", 32'(bus0.q_Idle), 32'd1);
        checkOutput("areset_y", 32'(bus0.doodle_y), 32'd480);
        checkOutput("areset_up", 32'(bus0.up_count), 32'd0);
        checkOutput("areset_score", 32'(bus0.score), 32'd0);
        checkOutput("areset_scroll2", 32'(bus2.scroll), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("post_reset_idle", 32'(bus0.q_Idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/doodle_motion_ctrl.md
DOODLE_MOTION_CTRL -- requirements
Module: doodle_motion_ctrl

Interface
REQ-001 Parameter JUMP_HEIGHT, 10'd120, rise distance in pixels per jump.
REQ-002 Parameter Y_START, 10'd480, doodle centre row on game start.
REQ-003 Parameter V_MIDDLE, 10'd275, row at which rising stops moving the doodle and scrolls the stage instead.
REQ-004 Parameter V_BOTTOM, 10'd515, last visible row.
REQ-005 Parameter RADIUS, 10'd10, centre-to-bottom-edge distance of the doodle.
REQ-006 Clk  input  1  system clock.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame; advances motion.
REQ-009 start  input  1  begin game (sampled in IDLE only).
REQ-010 ack  input  1  acknowledge game over (sampled in OVER only).
REQ-011 landed  input  1  collision checker reports doodle bottom on a platform (sampled in FALL only).
REQ-012 doodle_y  output  10  doodle centre row, screen coordinates.
REQ-013 up_count  output  10  pixels risen in current jump.
REQ-014 scroll  output  10  total stage scroll offset in pixels.
REQ-015 score  output  8  pixels risen this game, saturating.
REQ-016 in_middle  output  1  high when doodle_y <= V_MIDDLE.
REQ-017 q_Idle, q_Rise, q_Fall, q_Over  output  1 each  one-hot state indicators.

Function
REQ-018 Four one-hot states IDLE, RISE, FALL, OVER; exactly one q_* high at all times.
REQ-019 All outputs registered; every update occurs on the Clk edge where the condition is sampled (1-cycle latency).
REQ-020 IDLE: doodle_y = Y_START, up_count = 0, scroll = 0; start=1 -> RISE, score <= 0 on same edge; frame_tick ignored.
REQ-021 RISE, frame_tick=1, up_count >= JUMP_HEIGHT -> FALL, up_count <= 0, no movement that tick.
REQ-022 RISE, frame_tick=1, up_count < JUMP_HEIGHT: up_count +1; score +1 saturating at 255; if doodle_y > V_MIDDLE then doodle_y -1 else scroll +1 (doodle_y held).
REQ-023 scroll wraps modulo 1024 (1023 -> 0); up_count never wraps (bounded by JUMP_HEIGHT).
REQ-024 FALL, frame_tick=1: landed=1 -> RISE, up_count <= 0, doodle_y held; else if doodle_y + RADIUS >= V_BOTTOM -> OVER, doodle_y held; else doodle_y +1.
REQ-025 landed and bottom condition on same tick: landed wins (-> RISE).
REQ-026 landed, start, ack ignored outside their sampling state; without frame_tick, RISE/FALL hold all outputs.
REQ-027 OVER: all outputs held; ack=1 -> IDLE, doodle_y <= Y_START, up_count <= 0, scroll <= 0, score held until next start.
REQ-028 in_middle registered, updated with doodle_y (reflects new doodle_y on same edge).
REQ-029 Illegal state encoding -> IDLE on next Clk edge.

Reset
REQ-030 Reset=1 immediately forces IDLE, doodle_y = Y_START, up_count = 0, scroll = 0, score = 0, in_middle = (Y_START <= V_MIDDLE), independent of Clk.
REQ-031 Reset asserted mid-RISE/FALL discards the jump in progress; after release the block waits in IDLE for start.

Verification
REQ-032 JUMP_HEIGHT=4: start, 4 ticks -> doodle_y=476, up_count=4, score=4; 5th tick -> q_Fall, up_count=0, doodle_y=476.
REQ-033 Continue with landed=0: 29 ticks -> doodle_y=505; 30th tick -> q_Over, doodle_y=505; ack -> q_Idle, doodle_y=480, score=4.
REQ-034 Y_START=280, JUMP_HEIGHT=8: ticks 1-5 -> doodle_y 279..275, in_middle=1 after tick 5; ticks 6-8 -> scroll 1,2,3, doodle_y=275; tick 9 -> q_Fall.
REQ-035 In FALL with doodle_y=505, landed=1 on tick -> q_Rise, doodle_y=505, up_count=0 (landed beats bottom).
REQ-036 JUMP_HEIGHT=300: 300 ticks -> up_count=300, score=255 (saturated); scroll preset near 1023 wraps to 0.
REQ-037 Reset pulse mid-RISE between clock edges -> outputs at REQ-030 values immediately; start ignored in OVER, ack ignored in RISE.
